// File: rtl/drive_sequencer.sv
// rtl/drive_sequencer.sv - mode debounce, duty targets, slew ramp and line-loss recovery for two motor channels
module drive_sequencer #(
    parameter int TICK_DIV     = 25000,
    parameter int STEP         = 64,
    parameter int CRUISE       = 800,
    parameter int SHARP        = 1000,
    parameter int SEARCH_DUTY  = 600,
    parameter int FILT         = 4,
    parameter int HOLD_TICKS   = 200,
    parameter int SEARCH_TICKS = 1500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] mode,
    output logic [9:0] left_duty,
    output logic [9:0] right_duty,
    output logic [1:0] state,
    output logic       lost
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HOLD   = 2'b01,
        ST_SEARCH = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    localparam int TW    = $clog2(TICK_DIV + 1);
    localparam int FW    = $clog2(FILT + 1);
    localparam int LMAX  = (HOLD_TICKS > SEARCH_TICKS) ? HOLD_TICKS : SEARCH_TICKS;
    localparam int LW    = $clog2(LMAX + 2);

    localparam logic [9:0]        CRUISE_D = 10'(CRUISE);
    localparam logic [9:0]        SHARP_D  = 10'(SHARP);
    localparam logic [9:0]        SRCH_D   = 10'(SEARCH_DUTY);
    localparam logic [9:0]        STEP_D   = 10'(STEP);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    state_t          cur_state;
    state_t          nxt_state;
    logic [2:0]      prev_mode;
    logic [2:0]      fmode;
    logic [FW-1:0]   stable_cnt;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [LW-1:0]   lost_cnt;
    logic [LW-1:0]   nxt_lost_cnt;
    logic [LW-1:0]   lost_inc;
    logic            mode_valid;
    logic [9:0]      tbl_l;
    logic [9:0]      tbl_r;
    logic [9:0]      run_l;
    logic [9:0]      run_r;
    logic            last_dir;
    logic [9:0]      tgt_l;
    logic [9:0]      tgt_r;

    // Duty pair requested by a decoded mode, packed {left, right}; 000 means the line is gone.
    function automatic logic [19:0] mode_targets(input logic [2:0] m);
        case (m)
            3'b010, 3'b101, 3'b111: mode_targets = {CRUISE_D, CRUISE_D};
            3'b110:                 mode_targets = {10'd0, CRUISE_D};
            3'b011:                 mode_targets = {CRUISE_D, 10'd0};
            3'b001:                 mode_targets = {10'd0, SHARP_D};
            3'b100:                 mode_targets = {SHARP_D, 10'd0};
            default:                mode_targets = {10'd0, 10'd0};
        endcase
    endfunction

    // One slew step toward the target, snapping when within STEP so it never overshoots.
    function automatic logic [9:0] ramp(input logic [9:0] d, input logic [9:0] t);
        logic signed [10:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, d});
        if (diff > STEP_S)
            ramp = d + STEP_D;
        else if (diff < -STEP_S)
            ramp = d - STEP_D;
        else
            ramp = t;
    endfunction

    assign mode_valid     = (fmode != 3'b000);
    assign {tbl_l, tbl_r} = mode_targets(fmode);
    assign tick           = (tick_cnt == TW'(TICK_DIV - 1));
    assign lost_inc       = lost_cnt + 1'b1;
    assign state          = cur_state;

    // Accept a raw mode only after it has matched the previous sample FILT times in a row.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_mode  <= 3'b000;
            stable_cnt <= '0;
            fmode      <= 3'b000;
        end else begin
            prev_mode <= mode;
            if (mode != prev_mode) begin
                stable_cnt <= '0;
            end else begin
                if (stable_cnt != FW'(FILT))
                    stable_cnt <= stable_cnt + 1'b1;
                if (stable_cnt >= FW'(FILT - 1))
                    fmode <= mode;
            end
        end
    end

    // Free-running ramp/timeout prescaler; tick fires on the wrap cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Next state, timeout counter and the targets of the state being entered.
    always_comb begin
        nxt_state    = cur_state;
        nxt_lost_cnt = lost_cnt;
        tgt_l        = 10'd0;
        tgt_r        = 10'd0;
        if (!enable) begin
            nxt_state    = ST_HALT;
            nxt_lost_cnt = '0;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (!mode_valid) begin
                        nxt_state    = ST_HOLD;
                        nxt_lost_cnt = '0;
                    end
                end
                ST_HOLD: begin
                    if (mode_valid) begin
                        nxt_state    = ST_RUN;
                        nxt_lost_cnt = '0;
                    end else if (tick) begin
                        if (lost_inc == LW'(HOLD_TICKS)) begin
                            nxt_state    = ST_SEARCH;
                            nxt_lost_cnt = '0;
                        end else begin
                            nxt_lost_cnt = lost_inc;
                        end
                    end
                end
                ST_SEARCH: begin
                    if (mode_valid) begin
                        nxt_state    = ST_RUN;
                        nxt_lost_cnt = '0;
                    end else if (tick) begin
                        if (lost_inc == LW'(SEARCH_TICKS)) begin
                            nxt_state    = ST_HALT;
                            nxt_lost_cnt = '0;
                        end else begin
                            nxt_lost_cnt = lost_inc;
                        end
                    end
                end
                default: begin
                    nxt_lost_cnt = '0;
                    if (mode_valid)
                        nxt_state = ST_RUN;
                end
            endcase
        end
        case (nxt_state)
            ST_RUN: begin
                tgt_l = tbl_l;
                tgt_r = tbl_r;
            end
            ST_HOLD: begin
                tgt_l = run_l;
                tgt_r = run_r;
            end
            ST_SEARCH: begin
                tgt_l = last_dir ? SRCH_D : 10'd0;
                tgt_r = last_dir ? 10'd0 : SRCH_D;
            end
            default: begin
                tgt_l = 10'd0;
                tgt_r = 10'd0;
            end
        endcase
    end

    // State register plus the registered lost flag that moves with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= ST_HALT;
            lost_cnt  <= '0;
            lost      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            lost_cnt  <= nxt_lost_cnt;
            lost      <= (nxt_state == ST_HOLD) || (nxt_state == ST_SEARCH);
        end
    end

    // Remember the RUN targets for HOLD and which side the line was last seen on for SEARCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_l    <= 10'd0;
            run_r    <= 10'd0;
            last_dir <= 1'b0;
        end else if (enable && nxt_state == ST_RUN) begin
            run_l <= tbl_l;
            run_r <= tbl_r;
            if (tbl_l > tbl_r)
                last_dir <= 1'b1;
            else if (tbl_l < tbl_r)
                last_dir <= 1'b0;
        end
    end

    // Duties move only on a tick, except the immediate emergency-stop force to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_duty  <= 10'd0;
            right_duty <= 10'd0;
        end else if (!enable) begin
            left_duty  <= 10'd0;
            right_duty <= 10'd0;
        end else if (tick) begin
            left_duty  <= ramp(left_duty, tgt_l);
            right_duty <= ramp(right_duty, tgt_r);
        end
    end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb/tb_drive_sequencer.sv - randomized and directed checks of drive_sequencer against a behavioural model
module tb_drive_sequencer;

    localparam int TICK_DIV     = 4;
    localparam int STEP         = 100;
    localparam int CRUISE       = 800;
    localparam int SHARP        = 1000;
    localparam int SEARCH_DUTY  = 600;
    localparam int FILT         = 2;
    localparam int HOLD_TICKS   = 3;
    localparam int SEARCH_TICKS = 5;

    localparam int S_RUN = 0, S_HOLD = 1, S_SEARCH = 2, S_HALT = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] mode;
    logic [9:0] left_duty;
    logic [9:0] right_duty;
    logic [1:0] state;
    logic       lost;

    int errors = 0;
    int checks = 0;

    int m_state, m_l, m_r, m_fmode, m_cycle, m_cnt, m_run_l, m_run_r, m_dir;
    int hist[$];

    drive_sequencer #(
        .TICK_DIV(TICK_DIV), .STEP(STEP), .CRUISE(CRUISE), .SHARP(SHARP),
        .SEARCH_DUTY(SEARCH_DUTY), .FILT(FILT), .HOLD_TICKS(HOLD_TICKS),
        .SEARCH_TICKS(SEARCH_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .left_duty(left_duty), .right_duty(right_duty), .state(state), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic int m_lost();
        return (m_state == S_HOLD || m_state == S_SEARCH) ? 1 : 0;
    endfunction

    function automatic void lookup(input int m, output int l, output int r);
        case (m)
            2, 5, 7: begin l = CRUISE; r = CRUISE; end
            6:       begin l = 0;      r = CRUISE; end
            3:       begin l = CRUISE; r = 0;      end
            1:       begin l = 0;      r = SHARP;  end
            4:       begin l = SHARP;  r = 0;      end
            default: begin l = 0;      r = 0;      end
        endcase
    endfunction

    function automatic int slew(input int d, input int t);
        int diff;
        diff = t - d;
        if (diff > STEP)  return d + STEP;
        if (diff < -STEP) return d - STEP;
        return t;
    endfunction

    task automatic model_reset();
        m_state = S_HALT; m_l = 0; m_r = 0; m_fmode = 0; m_cycle = 0;
        m_cnt = 0; m_run_l = 0; m_run_r = 0; m_dir = 0;
        hist.delete();
        hist.push_back(0);
    endtask

    task automatic model_step(input logic en, input logic [2:0] md);
        bit tk, valid, same;
        int ns, tl, tr, bl, br;
        tk = (m_cycle % TICK_DIV) == (TICK_DIV - 1);
        m_cycle++;
        valid = (m_fmode != 0);
        lookup(m_fmode, bl, br);
        ns = m_state;
        if (!en) begin
            ns = S_HALT; m_cnt = 0;
        end else if (m_state == S_RUN) begin
            if (!valid) begin ns = S_HOLD; m_cnt = 0; end
        end else if (valid) begin
            ns = S_RUN; m_cnt = 0;
        end else if (m_state == S_HOLD && tk) begin
            m_cnt++;
            if (m_cnt == HOLD_TICKS) begin ns = S_SEARCH; m_cnt = 0; end
        end else if (m_state == S_SEARCH && tk) begin
            m_cnt++;
            if (m_cnt == SEARCH_TICKS) begin ns = S_HALT; m_cnt = 0; end
        end
        if (ns == S_RUN) begin
            m_run_l = bl; m_run_r = br;
            if (bl > br) m_dir = 1;
            else if (bl < br) m_dir = 0;
        end
        case (ns)
            S_RUN:    begin tl = bl;      tr = br;      end
            S_HOLD:   begin tl = m_run_l; tr = m_run_r; end
            S_SEARCH: begin tl = m_dir ? SEARCH_DUTY : 0; tr = m_dir ? 0 : SEARCH_DUTY; end
            default:  begin tl = 0;       tr = 0;       end
        endcase
        if (!en) begin
            m_l = 0; m_r = 0;
        end else if (tk) begin
            m_l = slew(m_l, tl); m_r = slew(m_r, tr);
        end
        hist.push_back(int'(md));
        if (hist.size() > FILT + 1) void'(hist.pop_front());
        if (hist.size() == FILT + 1) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (same) m_fmode = int'(md);
        end
        m_state = ns;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(enable, mode);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0; mode = 3'b000;
        do_reset();
        checks++;
        if (left_duty !== 10'd0 || right_duty !== 10'd0 || state !== 2'b11 || lost !== 1'b0) begin
            errors++;
            $display("FAIL reset: got L=%0d R=%0d st=%0d lost=%0d, want 0 0 3 0", left_duty, right_duty, state, lost);
        end
    endtask

    task automatic test_ramp_up();
        enable = 1'b1; mode = 3'b111;
        for (int i = 0; i < 50; i++) begin
            cycle();
            checks++;
            if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                errors++;
                $display("FAIL ramp_up c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
            end
        end
        checks++;
        if (left_duty !== 10'd800 || right_duty !== 10'd800 || state !== 2'b00) begin
            errors++;
            $display("FAIL ramp_up_final: got L=%0d R=%0d st=%0d, want 800 800 0", left_duty, right_duty, state);
        end
    endtask

    task automatic test_turn();
        mode = 3'b110;
        for (int i = 0; i < 45; i++) begin
            cycle();
            checks++;
            if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                errors++;
                $display("FAIL turn c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
            end
        end
        checks++;
        if (left_duty !== 10'd0 || right_duty !== 10'd800) begin
            errors++;
            $display("FAIL turn_final: got L=%0d R=%0d, want 0 800", left_duty, right_duty);
        end
    endtask

    task automatic test_lost_recovery();
        int saw_hold, saw_search;
        saw_hold = 0; saw_search = 0;
        mode = 3'b000;
        for (int i = 0; i < 80; i++) begin
            cycle();
            if (m_state == S_HOLD) saw_hold = 1;
            if (m_state == S_SEARCH) saw_search = 1;
            checks++;
            if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                errors++;
                $display("FAIL lost c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
            end
            if (m_state == S_SEARCH && m_cnt == SEARCH_TICKS - 1) begin
                checks++;
                if (left_duty !== 10'd0 || right_duty !== 10'd600) begin
                    errors++;
                    $display("FAIL search_duty: got L=%0d R=%0d, want 0 600", left_duty, right_duty);
                end
            end
        end
        checks++;
        if (state !== 2'b11 || left_duty !== 10'd0 || right_duty !== 10'd0 || lost !== 1'b0 || saw_hold == 0 || saw_search == 0) begin
            errors++;
            $display("FAIL lost_final: got st=%0d L=%0d R=%0d lost=%0d, want 3 0 0 0 via hold and search", state, left_duty, right_duty, lost);
        end
    endtask

    task automatic test_glitch();
        mode = 3'b111;
        for (int i = 0; i < 50; i++) cycle();
        mode = 3'b000;
        cycle();
        mode = 3'b111;
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (state !== 2'b00 || lost !== 1'b0 || left_duty !== 10'(m_l) || right_duty !== 10'(m_r)) begin
                errors++;
                $display("FAIL glitch c%0d: got st=%0d lost=%0d L=%0d R=%0d, want 0 0 %0d %0d", i, state, lost, left_duty, right_duty, m_l, m_r);
            end
        end
    endtask

    task automatic test_enable_drop();
        enable = 1'b0;
        cycle();
        checks++;
        if (left_duty !== 10'd0 || right_duty !== 10'd0 || state !== 2'b11) begin
            errors++;
            $display("FAIL estop: got L=%0d R=%0d st=%0d, want 0 0 3", left_duty, right_duty, state);
        end
        for (int i = 0; i < 3; i++) cycle();
        enable = 1'b1; mode = 3'b010;
        for (int i = 0; i < 45; i++) begin
            cycle();
            checks++;
            if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                errors++;
                $display("FAIL reenable c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
            end
        end
        checks++;
        if (left_duty !== 10'd800 || right_duty !== 10'd800 || state !== 2'b00) begin
            errors++;
            $display("FAIL reenable_final: got L=%0d R=%0d st=%0d, want 800 800 0", left_duty, right_duty, state);
        end
    endtask

    task automatic test_async_reset();
        int n;
        mode = 3'b000;
        n = 0;
        while (m_state != S_SEARCH && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (m_state != S_SEARCH || state !== 2'b10) begin
            errors++;
            $display("FAIL reach_search: got st=%0d after %0d cycles, want 2", state, n);
        end
        cycle();
        cycle();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (left_duty !== 10'd0 || right_duty !== 10'd0 || state !== 2'b11 || lost !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got L=%0d R=%0d st=%0d lost=%0d, want 0 0 3 0", left_duty, right_duty, state, lost);
        end
        @(negedge clk);
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_timeout_race();
        int n;
        for (int k = 0; k < 13; k++) begin
            do_reset();
            enable = 1'b1; mode = 3'b111;
            for (int i = 0; i < 10; i++) cycle();
            mode = 3'b000;
            n = 0;
            while (m_state != S_HOLD && n < 20) begin
                cycle();
                n++;
            end
            for (int i = 0; i < k; i++) cycle();
            mode = 3'b011;
            for (int i = 0; i < 30; i++) begin
                cycle();
                checks++;
                if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                    errors++;
                    $display("FAIL race k%0d c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", k, i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
                end
            end
            checks++;
            if (state !== 2'b00 || left_duty !== 10'd800 || right_duty !== 10'd0) begin
                errors++;
                $display("FAIL race_final k%0d: got st=%0d L=%0d R=%0d, want 0 800 0", k, state, left_duty, right_duty);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0 || i == 0) begin
                mode   = 3'($urandom_range(0, 7));
                enable = ($urandom_range(0, 19) != 0);
                hold   = $urandom_range(1, 14);
            end
            hold--;
            cycle();
            checks++;
            if (left_duty !== 10'(m_l) || right_duty !== 10'(m_r) || state !== 2'(m_state) || lost !== 1'(m_lost())) begin
                errors++;
                $display("FAIL random c%0d: got L=%0d R=%0d st=%0d lost=%0d, want %0d %0d %0d %0d", i, left_duty, right_duty, state, lost, m_l, m_r, m_state, m_lost());
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 3'b000;
        model_reset();
        test_reset();
        test_ramp_up();
        test_turn();
        test_lost_recovery();
        test_glitch();
        test_enable_drop();
        test_async_reset();
        enable = 1'b1; mode = 3'b111;
        for (int i = 0; i < 20; i++) cycle();
        test_async_reset();
        test_timeout_race();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
